// File: rtl/fuzzy_eval_scheduler.sv
// ============================================================================
// fuzzy_eval_scheduler
// ----------------------------------------------------------------------------
// Time-multiplexed fuzzifier/decision controller for the fuzzy attack
// detector. A single triangular membership-function (MF) unit is shared
// across all features and membership sets. The corners of each triangle come
// from a programmable 12-entry table.
//
// For every accepted sample the features are walked in order:
// hamming_dist, energy, peak_power, mean_power.
//   - Each feature takes three EVAL cycles: the low, medium and high degrees.
//   - One CHECK cycle follows and decides the feature.
//   - The walk stops at the first feature that produces a decision.
//
// Latency: out_valid is first seen in cycle 4n+1 after acceptance. Cycle 1
// is the cycle that begins at the acceptance edge, and n is the number of
// features examined (1..4).
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid        sample valid
//   in_ready        sample accepted on in_valid & in_ready at a rising edge
//   hamming_dist    feature 0 (8 bits, zero-extended to 10)
//   energy          feature 1
//   peak_power      feature 2
//   mean_power      feature 3
//   cfg_we          corner-table write strobe (honoured in IDLE only)
//   cfg_addr        table index = feature*3 + set (0=low, 1=med, 2=high);
//                   12..15 are ignored
//   cfg_a/b/c       triangle corners
//   out_valid       result valid; held until out_ready
//   out_ready       result consumed on out_valid & out_ready
//   out_attack      1 = attack, 0 = normal
//   out_feature     index of the feature that decided
//
// Optional build macro FUZZY_SCHED_STATS_EN adds two outputs:
//   stat_samples    saturating count of consumed results
//   stat_attacks    saturating count of consumed attack results
// ============================================================================
module fuzzy_eval_scheduler #(
    parameter logic [10:0] DEGREE_THRESH = 11'd8,
    parameter int          NUM_FEATURES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  energy,
    input  logic [9:0]  peak_power,
    input  logic [9:0]  mean_power,
    input  logic [7:0]  hamming_dist,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [9:0]  cfg_a,
    input  logic [9:0]  cfg_b,
    input  logic [9:0]  cfg_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_attack,
    output logic [1:0]  out_feature
`ifdef FUZZY_SCHED_STATS_EN
    ,
    output logic [15:0] stat_samples,
    output logic [15:0] stat_attacks
`endif
);

    localparam int TABLE_DEPTH = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_CHECK,
        S_RESP
    } state_t;

    state_t state, state_n;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [9:0]  tbl_a [TABLE_DEPTH];
    logic [9:0]  tbl_b [TABLE_DEPTH];
    logic [9:0]  tbl_c [TABLE_DEPTH];

    logic [9:0]  feat_q [4];          // latched sample, indexed by feature
    logic [1:0]  f_idx;               // feature under evaluation
    logic [1:0]  s_idx;               // membership set under evaluation
    logic [10:0] deg_low, deg_med, deg_high;

    // ------------------------------------------------------------------
    // Decision signals from the FSM
    // ------------------------------------------------------------------
    logic        accept;
    logic        decide;
    logic        decide_attack;
    logic        last_feature;
    logic        low_win, high_win;

    // ------------------------------------------------------------------
    // Shared MF unit signals
    // ------------------------------------------------------------------
    logic [3:0]          tbl_idx;
    logic [9:0]          mf_x;
    logic signed [10:0]  sx, sa, sb, sc;
    logic signed [10:0]  mf_num, mf_den;
    logic signed [17:0]  num_w, den_w;
    logic [10:0]         mf_deg;

    // Table index = f*3 + s, built as (f<<1) + f + s.
    assign tbl_idx = {1'b0, f_idx, 1'b0} + {2'b00, f_idx} + {2'b00, s_idx};

    assign mf_x = feat_q[f_idx];

    // Operands are non-negative 10-bit values carried as signed 11-bit.
    assign sx = $signed({1'b0, mf_x});
    assign sa = $signed({1'b0, tbl_a[tbl_idx]});
    assign sb = $signed({1'b0, tbl_b[tbl_idx]});
    assign sc = $signed({1'b0, tbl_c[tbl_idx]});

    // Triangular membership:
    //   rising edge  ((x-a) << 7) / (b-a)
    //   falling edge ((c-x) << 7) / (c-b)
    // Inside the open interval (a, c) the denominator cannot be zero and the
    // result cannot be negative. Both guards are kept so the unit stays
    // well-defined for any corner ordering.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // otherwise a path that skips an assignment infers a latch.
        mf_num = '0;
        mf_den = '0;
        num_w  = '0;
        den_w  = '0;
        mf_deg = '0;
        if (!(sx <= sa || sx >= sc)) begin
            if (sx <= sb) begin
                mf_num = sx - sa;
                mf_den = sb - sa;
            end else begin
                mf_num = sc - sx;
                mf_den = sc - sb;
            end
            num_w = $signed({mf_num, 7'b000_0000});
            den_w = $signed({{7{mf_den[10]}}, mf_den});
            // A negative result needs operands of opposite sign; clamp it.
            if (mf_den != 11'sd0 && !(mf_num[10] ^ mf_den[10])) begin
                mf_deg = 11'(num_w / den_w);
            end
        end
    end

    // ------------------------------------------------------------------
    // Set-win rule: strictly above the threshold and not beaten by either
    // sibling set of the same feature. Ties between sets both count as
    // wins; high is tested first, so high takes priority over low.
    // ------------------------------------------------------------------
    assign low_win  = (deg_low  > DEGREE_THRESH) &&
                      (deg_low  >= deg_med) && (deg_low  >= deg_high);
    assign high_win = (deg_high > DEGREE_THRESH) &&
                      (deg_high >= deg_low) && (deg_high >= deg_med);

    assign last_feature = (f_idx == 2'(NUM_FEATURES - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values, independent of statement order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_n       = state;
        in_ready      = 1'b0;
        accept        = 1'b0;
        decide        = 1'b0;
        decide_attack = 1'b0;
        unique case (state)
            S_IDLE: begin
                // A config write has priority over sample acceptance.
                in_ready = !cfg_we && !rst;
                accept   = in_valid && in_ready;
                if (accept) begin
                    state_n = S_EVAL;
                end
            end
            S_EVAL: begin
                if (s_idx == 2'd2) begin
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (high_win) begin
                    decide        = 1'b1;
                    decide_attack = 1'b1;
                end else if (low_win || last_feature) begin
                    // The last feature is decided "normal" whenever high
                    // does not win.
                    decide = 1'b1;
                end
                state_n = decide ? S_RESP : S_EVAL;
            end
            S_RESP: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign out_valid = (state == S_RESP);

    // ------------------------------------------------------------------
    // Corner table: writable only in IDLE, so an in-flight sample always
    // sees a stable table.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this small register file is reset on purpose; zero
            // corners make every degree 0, giving a known "normal" result
            // before any configuration.
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                tbl_a[i] <= '0;
                tbl_b[i] <= '0;
                tbl_c[i] <= '0;
            end
        end else if (state == S_IDLE && cfg_we && cfg_addr < 4'(TABLE_DEPTH)) begin
            tbl_a[cfg_addr] <= cfg_a;
            tbl_b[cfg_addr] <= cfg_b;
            tbl_c[cfg_addr] <= cfg_c;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: sample latch, walk counters, degree registers and result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                feat_q[i] <= '0;
            end
            f_idx       <= '0;
            s_idx       <= '0;
            deg_low     <= '0;
            deg_med     <= '0;
            deg_high    <= '0;
            out_attack  <= 1'b0;
            out_feature <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        feat_q[0] <= {2'b00, hamming_dist};
                        feat_q[1] <= energy;
                        feat_q[2] <= peak_power;
                        feat_q[3] <= mean_power;
                        f_idx     <= '0;
                        s_idx     <= '0;
                    end
                end
                S_EVAL: begin
                    unique case (s_idx)
                        2'd0:    deg_low  <= mf_deg;
                        2'd1:    deg_med  <= mf_deg;
                        default: deg_high <= mf_deg;
                    endcase
                    s_idx <= (s_idx == 2'd2) ? 2'd0 : s_idx + 2'd1;
                end
                S_CHECK: begin
                    if (decide) begin
                        out_attack  <= decide_attack;
                        out_feature <= f_idx;
                    end else begin
                        f_idx <= f_idx + 2'd1;
                        s_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FUZZY_SCHED_STATS_EN
    // ------------------------------------------------------------------
    // Saturating result counters, stepped on each output handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_samples <= '0;
            stat_attacks <= '0;
        end else if (out_valid && out_ready) begin
            if (stat_samples != 16'hFFFF) begin
                stat_samples <= stat_samples + 16'd1;
            end
            if (out_attack && stat_attacks != 16'hFFFF) begin
                stat_attacks <= stat_attacks + 16'd1;
            end
        end
    end
`endif

endmodule
